// File: rtl/pm_entry_tx.sv
// PM entry transmit side: issues a sideband L1/L2 entry request, then waits
// for the matching response, a PM NAK, or a microsecond-based timeout.
// All outputs are registered; i_en low returns the block to IDLE.
module pm_entry_tx #(
    parameter int unsigned TIMEOUT_US = 8000,
    parameter int unsigned US_CYC_100 = 100,
    parameter int unsigned US_CYC_200 = 200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_req_L1_or_L2,
    input  logic       i_clk_div_ratio,
    input  logic       i_msg_done,
    input  logic       i_msg_valid,
    input  logic [3:0] i_msg_no,
    output logic       o_msg_valid,
    output logic [3:0] o_msg_no,
    output logic       o_test_done,
    output logic       o_pm_nak,
    output logic       o_force_exit
);

    localparam logic [3:0] REQ_L1    = 4'd2;
    localparam logic [3:0] REQ_L2    = 4'd3;
    localparam logic [3:0] RSP_PMNAK = 4'd9;
    localparam logic [3:0] RSP_L1    = 4'd10;
    localparam logic [3:0] RSP_L2    = 4'd11;

    localparam int unsigned US_W   = (TIMEOUT_US < 2) ? 1 : $clog2(TIMEOUT_US + 1);
    localparam int unsigned PS_MAX = (US_CYC_100 > US_CYC_200) ? US_CYC_100 : US_CYC_200;
    localparam int unsigned PS_W   = (PS_MAX < 2) ? 1 : $clog2(PS_MAX);

    localparam logic [PS_W-1:0] PS_LAST_100 = PS_W'(US_CYC_100 - 1);
    localparam logic [PS_W-1:0] PS_LAST_200 = PS_W'(US_CYC_200 - 1);
    localparam logic [US_W-1:0] US_LAST     = US_W'(TIMEOUT_US - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_REQ,
        WAIT_RESP,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic            req_l2, req_l2_nx;
    logic            div_200, div_200_nx;
    logic            pend_vld, pend_vld_nx;
    logic            pend_nak, pend_nak_nx;
    logic [PS_W-1:0] presc, presc_nx;
    logic [US_W-1:0] us_cnt, us_cnt_nx;
    logic            msg_valid, msg_valid_nx;
    logic [3:0]      msg_no, msg_no_nx;
    logic            test_done, test_done_nx;
    logic            pm_nak, pm_nak_nx;
    logic            force_exit, force_exit_nx;

    logic [3:0]      exp_code;
    logic            resp_hit;
    logic            resp_nak;
    logic            presc_last;

    assign exp_code   = req_l2 ? RSP_L2 : RSP_L1;
    assign resp_nak   = (i_msg_no == RSP_PMNAK);
    assign resp_hit   = i_msg_valid && ((i_msg_no == exp_code) || resp_nak);
    assign presc_last = (presc == (div_200 ? PS_LAST_200 : PS_LAST_100));

    assign o_msg_valid  = msg_valid;
    assign o_msg_no     = msg_no;
    assign o_test_done  = test_done;
    assign o_pm_nak     = pm_nak;
    assign o_force_exit = force_exit;

    // State, latched request attributes, timer and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            req_l2     <= 1'b0;
            div_200    <= 1'b0;
            pend_vld   <= 1'b0;
            pend_nak   <= 1'b0;
            presc      <= '0;
            us_cnt     <= '0;
            msg_valid  <= 1'b0;
            msg_no     <= '0;
            test_done  <= 1'b0;
            pm_nak     <= 1'b0;
            force_exit <= 1'b0;
        end else begin
            state      <= state_nx;
            req_l2     <= req_l2_nx;
            div_200    <= div_200_nx;
            pend_vld   <= pend_vld_nx;
            pend_nak   <= pend_nak_nx;
            presc      <= presc_nx;
            us_cnt     <= us_cnt_nx;
            msg_valid  <= msg_valid_nx;
            msg_no     <= msg_no_nx;
            test_done  <= test_done_nx;
            pm_nak     <= pm_nak_nx;
            force_exit <= force_exit_nx;
        end
    end

    // Next-state, pending-response, timer and next-output decode
    always_comb begin
        state_nx      = state;
        req_l2_nx     = req_l2;
        div_200_nx    = div_200;
        pend_vld_nx   = pend_vld;
        pend_nak_nx   = pend_nak;
        presc_nx      = presc;
        us_cnt_nx     = us_cnt;
        msg_valid_nx  = msg_valid;
        msg_no_nx     = msg_no;
        test_done_nx  = test_done;
        pm_nak_nx     = pm_nak;
        force_exit_nx = force_exit;

        if (!i_en) begin
            state_nx      = IDLE;
            req_l2_nx     = 1'b0;
            div_200_nx    = 1'b0;
            pend_vld_nx   = 1'b0;
            pend_nak_nx   = 1'b0;
            presc_nx      = '0;
            us_cnt_nx     = '0;
            msg_valid_nx  = 1'b0;
            msg_no_nx     = '0;
            test_done_nx  = 1'b0;
            pm_nak_nx     = 1'b0;
            force_exit_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx     = SEND_REQ;
                    req_l2_nx    = i_req_L1_or_L2;
                    div_200_nx   = i_clk_div_ratio;
                    pend_vld_nx  = 1'b0;
                    pend_nak_nx  = 1'b0;
                    presc_nx     = '0;
                    us_cnt_nx    = '0;
                    msg_valid_nx = 1'b1;
                    msg_no_nx    = i_req_L1_or_L2 ? REQ_L2 : REQ_L1;
                end
                SEND_REQ: begin
                    if (i_msg_done) begin
                        msg_valid_nx = 1'b0;
                        // A response seen on the msg_done edge itself counts as pending
                        if (pend_vld || resp_hit) begin
                            state_nx     = DONE;
                            test_done_nx = 1'b1;
                            pm_nak_nx    = pend_vld ? pend_nak : resp_nak;
                        end else begin
                            state_nx  = WAIT_RESP;
                            presc_nx  = '0;
                            us_cnt_nx = '0;
                        end
                    end else if (!pend_vld && resp_hit) begin
                        pend_vld_nx = 1'b1;
                        pend_nak_nx = resp_nak;
                    end
                end
                WAIT_RESP: begin
                    if (resp_hit) begin
                        state_nx     = DONE;
                        test_done_nx = 1'b1;
                        pm_nak_nx    = resp_nak;
                    end else if (presc_last) begin
                        presc_nx  = '0;
                        us_cnt_nx = us_cnt + 1'b1;
                        if (us_cnt == US_LAST) begin
                            state_nx      = DONE;
                            test_done_nx  = 1'b1;
                            pm_nak_nx     = 1'b1;
                            force_exit_nx = 1'b1;
                        end
                    end else begin
                        presc_nx = presc + 1'b1;
                    end
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pm_entry_tx.md
PM_ENTRY_TX -- requirements
Module: pm_entry_tx

Interface
REQ-001 Parameter TIMEOUT_US, default 8000, meaning response timeout in microseconds.
REQ-002 Parameter US_CYC_100, default 100, meaning cycles per 1 us at 100 MHz. Parameter US_CYC_200, default 200, meaning cycles per 1 us at 200 MHz.
REQ-003 i_clk  in  1  clock. i_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_en  in  1  PM entry enable from the RDI FSM.
REQ-005 i_req_L1_or_L2  in  1  requested state: 0 selects L1, 1 selects L2.
REQ-006 i_clk_div_ratio  in  1  clock rate: 0 means 100 MHz, 1 means 200 MHz.
REQ-007 i_msg_done  in  1  sideband has sent the current outbound message.
REQ-008 i_msg_valid  in  1  inbound sideband message valid. i_msg_no  in  4  inbound message code.
REQ-009 o_msg_valid  out  1  outbound request valid. o_msg_no  out  4  outbound message code.
REQ-010 o_test_done  out  1  flow finished. o_pm_nak  out  1  flow ended with NAK or timeout.
REQ-011 o_force_exit  out  1  timeout indication to pm_entry_rx, which forces rx o_test_done.

Function
REQ-012 Message codes SHALL be: Req_L1=2, Req_L2=3, Rsp_PMNAK=9, Rsp_L1=10, Rsp_L2=11.
REQ-013 The FSM SHALL have four states: IDLE, SEND_REQ, WAIT_RESP, DONE.
REQ-014 IDLE: when i_en=1 at a clock edge, go to SEND_REQ on that edge.
  - Latch i_req_L1_or_L2 and i_clk_div_ratio into internal registers; they stay fixed until the next IDLE.
  - Set o_msg_no to 2 (L1) or 3 (L2).
  - Set o_msg_valid to 1.
REQ-015 SEND_REQ: hold o_msg_valid=1 and o_msg_no stable until i_msg_done=1.
  - On that edge, clear o_msg_valid.
  - Go to DONE if a response is pending (REQ-017); otherwise go to WAIT_RESP.
REQ-016 The expected response SHALL be 10 when L1 is latched and 11 when L2 is latched.
  - A response is an edge where i_msg_valid=1 and i_msg_no equals the expected code or 9.
  - All other codes SHALL be ignored, including the mismatched Rsp code.
REQ-017 A response that arrives in SEND_REQ SHALL be latched into a pending flag (ACK or NAK).
  - The first response received wins; later ones are ignored.
REQ-018 WAIT_RESP: on an expected Rsp, go to DONE with o_test_done=1 and o_pm_nak=0.
  - On Rsp_PMNAK, go to DONE with o_test_done=1 and o_pm_nak=1.
REQ-019 The timer SHALL run only in WAIT_RESP and SHALL start at 0 on entry.
  - A prescaler counts 0..N-1, with N=US_CYC_100 or US_CYC_200 per the latched ratio.
  - A microsecond counter (width ceil(log2(TIMEOUT_US+1))) increments on each prescaler wrap.
REQ-020 Timeout SHALL occur when the microsecond counter equals TIMEOUT_US, i.e. TIMEOUT_US*N cycles after entering WAIT_RESP.
  - On timeout, go to DONE with o_test_done=1, o_pm_nak=1 and o_force_exit=1.
REQ-021 If a response and a timeout occur on the same edge, the response SHALL take priority.
REQ-022 DONE: hold o_test_done, o_pm_nak and o_force_exit until i_en=0.
  - Responses arriving in DONE SHALL be ignored.
REQ-023 From any state, i_en=0 at an edge SHALL send the FSM to IDLE on that edge.
  - All outputs, the pending flag and the counters clear on the same edge.
  - This applies mid-request, even with o_msg_valid=1.
REQ-024 i_msg_done SHALL be ignored outside SEND_REQ.
REQ-025 The timer SHALL NOT wrap. At timeout, the counters SHALL hold until the FSM leaves DONE.
REQ-026 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-027 On i_rst_n=0, the FSM SHALL go to IDLE asynchronously.
  - o_msg_valid=0, o_msg_no=0, o_test_done=0, o_pm_nak=0, o_force_exit=0.
  - Counters and the pending flag clear.
REQ-028 After reset is released, the block SHALL wait for i_en=1 before issuing a request.

Verification
REQ-029 L1 ACK:
  - Stimulus: i_en=1, L1, i_msg_done after 3 cycles, then i_msg_valid with code 10.
  - Response: o_msg_no=2 and o_msg_valid for 4 cycles; o_test_done=1 and o_pm_nak=0 on the edge after the response; outputs clear on i_en=0.
REQ-030 L2 NAK:
  - Stimulus: L2 request, then code 11 ignored if it arrives as code 10, then code 9.
  - Response: o_msg_no=3; code 10 causes no effect; code 9 gives o_test_done=1 and o_pm_nak=1.
REQ-031 Timeout:
  - Stimulus: TIMEOUT_US=2, i_clk_div_ratio=0, no response.
  - Response: o_force_exit=1, o_pm_nak=1, o_test_done=1 exactly 200 cycles after WAIT_RESP entry. With ratio 1, 400 cycles.
REQ-032 Early response: code 10 arrives in SEND_REQ before i_msg_done.
  - Response: the FSM goes to DONE on the i_msg_done edge, with o_test_done=1 and o_pm_nak=0.
REQ-033 Collision and abort:
  - Stimulus 1: response on the timeout edge. Response: o_force_exit=0.
  - Stimulus 2: i_en=0 while o_msg_valid=1. Response: next edge shows IDLE with all outputs 0.
REQ-034 Async reset asserted in WAIT_RESP mid-count: all outputs go to 0 immediately and the counters clear.
